// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment width and active-low {a,b,c,d,e,f,g} patterns for hex digits
package seven_seg_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seven_seg_scan_driver_decode.sv
// seg_hex_decode: combinational nibble to active-low 7-segment pattern
module seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg
);
  always_comb
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed common-anode digit scanner with blank gap, leading-zero blanking and frame-synchronous double buffer
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [SEG_W-1:0]        seg_n,
  output logic                    dp_n,
  output logic                    frame_start
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] pend, disp;
  logic [NUM_DIGITS-1:0] pend_dp, disp_dp;
  logic pend_vld, slot_end, wrap, blank, lz, dp_lit, an_on;
  logic [3:0] nib;
  logic [SEG_W-1:0] seg;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [SEG_W-1:0] seg_nxt;
  logic dp_nxt;
  seg_hex_decode u_dec (.nib(nib), .seg(seg));
  always_comb begin
    slot_end = cnt == CNT_LAST;
    wrap = slot_end && idx == IDX_LAST;
    nib = disp[{idx, 2'b00} +: 4];
    blank = cnt < BLANK_END;
    lz = LZ_BLANK != 0 && idx != '0 && (disp >> {idx, 2'b00}) == '0;
    dp_lit = disp_dp[idx];
    an_on = !blank && (!lz || dp_lit);
    an_nxt = an_on ? ~(NUM_DIGITS'(1) << idx) : '1;
    seg_nxt = (blank || lz) ? SEG_BLANK : seg;
    dp_nxt = blank || !dp_lit;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      pend <= '0;
      pend_dp <= '0;
      pend_vld <= 1'b0;
      disp <= '0;
      disp_dp <= '0;
      an_n <= '1;
      seg_n <= SEG_BLANK;
      dp_n <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      idx <= slot_end ? (idx == IDX_LAST ? '0 : idx + 1'b1) : idx;
      pend <= load ? value_in : pend;
      pend_dp <= load ? dp_in : pend_dp;
      pend_vld <= load || (pend_vld && !wrap);
      disp <= wrap && pend_vld ? pend : disp;
      disp_dp <= wrap && pend_vld ? pend_dp : disp_dp;
      an_n <= an_nxt;
      seg_n <= seg_nxt;
      dp_n <= dp_nxt;
      frame_start <= wrap;
    end
endmodule
